// File: rtl/intt_ctrl_if.sv
// intt_ctrl_if: control and memory-sequencing bus of the INTT controller.
// master = INTT wrapper / datapath side, slave = intt_ctrl.
// Signals:
//   start                   wrapper -> ctrl, begin a transform
//   busy, done, stage       ctrl -> wrapper, progress/status
//   rd_en, rd_addr_a/b      ctrl -> RAM, operand reads
//   tw_addr                 ctrl -> ROM, inverse-twiddle read
//   bf_valid                ctrl -> butterfly, inputs valid
//   wr_en, wr_addr_a/b      ctrl -> RAM, result write-back
//   scale_mode              ctrl -> butterfly, only with INTT_SCALE_EN
interface intt_ctrl_if #(
    parameter int ADDR_W  = 8,
    parameter int STAGE_W = 4
);

    logic              start;
    logic              busy;
    logic              done;
    logic [STAGE_W-1:0] stage;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [ADDR_W-1:0] tw_addr;
    logic              bf_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
`ifdef INTT_SCALE_EN
    logic              scale_mode;
`endif

    modport master (
        output start,
        input  busy,
        input  done,
        input  stage,
        input  rd_en,
        input  rd_addr_a,
        input  rd_addr_b,
        input  tw_addr,
        input  bf_valid,
        input  wr_en,
        input  wr_addr_a,
        input  wr_addr_b
`ifdef INTT_SCALE_EN
        , input scale_mode
`endif
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output stage,
        output rd_en,
        output rd_addr_a,
        output rd_addr_b,
        output tw_addr,
        output bf_valid,
        output wr_en,
        output wr_addr_a,
        output wr_addr_b
`ifdef INTT_SCALE_EN
        , output scale_mode
`endif
    );

endinterface

// File: rtl/intt_ctrl.sv
// intt_ctrl: in-place Gentleman-Sande INTT sequencer, one butterfly/cycle.
// Ports: clk, rst_n (async, active low), bus (intt_ctrl_if.slave).
// Per stage s: N/2 reads, then a drain of MEM_LATENCY+BF_LATENCY cycles
// so every write of stage s lands before stage s+1 reads.
// Write-back valid/addresses come from a free-running delay line.
// Optional macro INTT_SCALE_EN: extra SCALE pass multiplying by N^-1
// (ROM entry 0), flagged on bus.scale_mode.
module intt_ctrl #(
    parameter int N           = 256,
    parameter int LOG_N       = $clog2(N),
    parameter int ADDR_W      = $clog2(N),
    parameter int MEM_LATENCY = 1,
    parameter int BF_LATENCY  = 4
) (
    input logic       clk,
    input logic       rst_n,
    intt_ctrl_if.slave bus
);

    localparam int D       = MEM_LATENCY + BF_LATENCY;
    localparam int STAGE_W = $clog2(LOG_N + 1);
    localparam int J_W     = ADDR_W - 1;
    localparam int DC_W    = $clog2(D + 1);

    localparam logic [J_W-1:0]     J_LAST   = J_W'(N / 2 - 1);
    localparam logic [STAGE_W-1:0] STG_LAST = STAGE_W'(LOG_N - 1);
    localparam logic [DC_W-1:0]    D_LAST   = DC_W'(D - 1);
    localparam logic [ADDR_W:0]    N_W      = (ADDR_W + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_SCALE,
        S_SDRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [J_W-1:0]     j_q, j_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [DC_W-1:0]    dc_q, dc_d;

    logic               rd_go;
    logic [ADDR_W-1:0]  ra, rb, tw;
    logic [ADDR_W-1:0]  jx, grp, idx, len;
    logic [STAGE_W-1:0] sp1;

    logic [D-1:0]       vld_q;
    logic [ADDR_W-1:0]  wa_q [D];
    logic [ADDR_W-1:0]  wb_q [D];

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            s_q     <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            s_q     <= s_d;
            dc_q    <= dc_d;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        s_d     = s_q;
        dc_d    = dc_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    j_d     = '0;
                    s_d     = '0;
                end
            end
            S_RUN: begin
                j_d = j_q + 1'b1;
                if (j_q == J_LAST) begin
                    state_d = S_DRAIN;
                    j_d     = '0;
                    dc_d    = '0;
                end
            end
            S_DRAIN: begin
                dc_d = dc_q + 1'b1;
                if (dc_q == D_LAST) begin
                    dc_d = '0;
                    if (s_q != STG_LAST) begin
                        s_d     = s_q + 1'b1;
                        state_d = S_RUN;
                    end else begin
`ifdef INTT_SCALE_EN
                        // Scaling pass reported as stage LOG_N
                        s_d     = STAGE_W'(LOG_N);
                        state_d = S_SCALE;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_SCALE: begin
                j_d = j_q + 1'b1;
                if (j_q == J_LAST) begin
                    state_d = S_SDRAIN;
                    j_d     = '0;
                    dc_d    = '0;
                end
            end
            S_SDRAIN: begin
                dc_d = dc_q + 1'b1;
                if (dc_q == D_LAST) begin
                    dc_d    = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                s_d     = '0;
                j_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- Read address generation ----------------
    // group = j>>s, idx = j&(len-1), a = group*2*len + idx.
    // Addresses are forced to 0 when no read is issued, so idle
    // outputs and the write delay line stay at 0.
    always_comb begin
        rd_go = (state_q == S_RUN) || (state_q == S_SCALE);
        jx    = {1'b0, j_q};
        sp1   = s_q + 1'b1;
        len   = ADDR_W'(1) << s_q;
        grp   = jx >> s_q;
        idx   = jx & (len - ADDR_W'(1));
        ra    = '0;
        rb    = '0;
        tw    = '0;
        if (state_q == S_RUN) begin
            ra = (grp << sp1) | idx;
            rb = ra | len;
            tw = ADDR_W'(N_W >> sp1) + grp;
        end else if (state_q == S_SCALE) begin
            ra = {j_q, 1'b0};
            rb = {j_q, 1'b1};
        end
    end

    // ---------------- Write-back delay line ----------------
    // Free-running: completes in-flight writes during DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < D; i++) begin
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_go;
            wa_q[0]  <= ra;
            wb_q[0]  <= rb;
            for (int i = 1; i < D; i++) begin
                vld_q[i] <= vld_q[i-1];
                wa_q[i]  <= wa_q[i-1];
                wb_q[i]  <= wb_q[i-1];
            end
        end
    end

    // ---------------- Outputs ----------------
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.stage     = s_q;
    assign bus.rd_en     = rd_go;
    assign bus.rd_addr_a = ra;
    assign bus.rd_addr_b = rb;
    assign bus.tw_addr   = tw;
    assign bus.bf_valid  = vld_q[MEM_LATENCY-1];
    assign bus.wr_en     = vld_q[D-1];
    assign bus.wr_addr_a = wa_q[D-1];
    assign bus.wr_addr_b = wb_q[D-1];
`ifdef INTT_SCALE_EN
    assign bus.scale_mode = (state_q == S_SCALE) ||
                            (state_q == S_SDRAIN);
`endif

endmodule
